// File: rtl/uart_echo_tester_pkg.sv
// Shared types, constants and LFSR helpers for the UART echo tester.
package uart_echo_tester_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ECHO = 2'd2,
    DONE      = 2'd3
  } tester_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_DATA    = 2'b01,
    FC_FRAMING = 2'b10,
    FC_TIMEOUT = 2'b11
  } fail_code_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One step of the 8-bit right-shifting Galois LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

  // The all-zero state would lock the LFSR up, so it is never used as a seed.
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/uart_echo_tester_if.sv
// Byte-level link between the tester and the uart_tx/uart_rx pair.
interface uart_echo_tester_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_framing_error;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, rx_data, rx_ready, rx_framing_error
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, rx_data, rx_ready, rx_framing_error
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Galois PRBS generator with seed load and single-step advance.
module lfsr8
  import uart_echo_tester_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] lfsr_d;
  logic [7:0] lfsr_q;

  // Next value: a load wins over a step so a restart always begins at the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = fix_seed(seed);
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register, reset to the seed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= fix_seed(seed);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/uart_echo_tester.sv
// Stop-and-wait echo tester: sends PRBS bytes and checks each echoed byte.
module uart_echo_tester
  import uart_echo_tester_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  uart_echo_tester_if.master        uart,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                fail_code,
  output logic [15:0]               error_count,
  output logic [15:0]               bytes_checked
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   LAST_COUNT = 16'(NUM_BYTES);

  tester_state_t state_d, state_q;
  fail_code_t    fail_code_d, fail_code_q;
  logic          tx_start_d, tx_start_q;
  logic [7:0]    tx_data_d, tx_data_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          pass_d, pass_q;
  logic [15:0]   err_d, err_q;
  logic [15:0]   bytes_d, bytes_q;
  logic [TW-1:0] timer_d, timer_q;
  logic          lfsr_load_s, lfsr_step_s;
  logic [7:0]    lfsr_s;
  logic          byte_err_s, finish_s;
  fail_code_t    code_s;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load_s),
    .seed    (SEED),
    .step    (lfsr_step_s),
    .q       (lfsr_s)
  );

  // Next-state and output logic; error bookkeeping is shared by every error source.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    bytes_d     = bytes_q;
    timer_d     = timer_q;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    byte_err_s  = 1'b0;
    finish_s    = 1'b0;
    code_s      = FC_NONE;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SEND;
          fail_code_d = FC_NONE;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = 16'd0;
          bytes_d     = 16'd0;
          timer_d     = '0;
          lfsr_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      SEND: begin
        // An echo while nothing is in flight is counted as a data error.
        if (uart.rx_ready) begin
          byte_err_s = 1'b1;
          code_s     = FC_DATA;
        end else begin
          byte_err_s = 1'b0;
        end
        if (!uart.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = lfsr_s;
          timer_d    = '0;
          state_d    = WAIT_ECHO;
        end else begin
          state_d = SEND;
        end
      end
      WAIT_ECHO: begin
        timer_d = timer_q + 1'b1;
        // A byte arriving on the timeout cycle is accepted instead of timing out.
        if (uart.rx_ready) begin
          bytes_d     = bytes_q + 16'd1;
          lfsr_step_s = 1'b1;
          if (uart.rx_framing_error) begin
            byte_err_s = 1'b1;
            code_s     = FC_FRAMING;
          end else if (uart.rx_data != tx_data_q) begin
            byte_err_s = 1'b1;
            code_s     = FC_DATA;
          end else begin
            byte_err_s = 1'b0;
          end
          if (bytes_q + 16'd1 == LAST_COUNT) begin
            finish_s = 1'b1;
          end else begin
            state_d = SEND;
          end
        end else if (timer_q == TIMER_LAST) begin
          byte_err_s = 1'b1;
          code_s     = FC_TIMEOUT;
          finish_s   = 1'b1;
        end else begin
          state_d = WAIT_ECHO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (byte_err_s) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      fail_code_d = (fail_code_q == FC_NONE) ? code_s : fail_code_q;
    end else begin
      err_d = err_d;
    end

    if (finish_s) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == 16'd0);
    end else begin
      done_d = done_d;
    end
  end

  // Registers; reset aborts any run without reporting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fail_code_q <= FC_NONE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 16'd0;
      bytes_q     <= 16'd0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      bytes_q     <= bytes_d;
      timer_q     <= timer_d;
    end
  end

  assign uart.tx_start  = tx_start_q;
  assign uart.tx_data   = tx_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_code      = fail_code_q;
  assign error_count    = err_q;
  assign bytes_checked  = bytes_q;

endmodule
